// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: sequences each instruction
// over several clocks and decodes the state register into datapath controls.
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       jump_reg,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [3:0] S_IDLE = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,
                         S_MADDR = 4'd3, S_MREAD = 4'd4,  S_MWB = 4'd5,
                         S_MWRITE = 4'd6, S_EXEC = 4'd7,  S_RWB = 4'd8,
                         S_BRANCH = 4'd9, S_JUMP = 4'd10, S_IEXEC = 4'd11,
                         S_IWB = 4'd12;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04,
                         OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_ORI = 6'h0D,
                         OP_LW = 6'h23, OP_SW = 6'h2B;

  logic [3:0] r_state;
  logic [3:0] w_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:             w_next = S_MADDR;
          OP_R:                     w_next = S_EXEC;
          OP_BEQ:                   w_next = S_BRANCH;
          OP_J:                     w_next = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI: w_next = S_IEXEC;
          default:                  w_next = S_FETCH;
        endcase
      end
      S_MADDR:  w_next = (opcode == OP_SW) ? S_MWRITE : S_MREAD;
      S_MREAD:  w_next = mem_ready ? S_MWB : S_MREAD;
      S_MWRITE: w_next = mem_ready ? S_FETCH : S_MWRITE;
      S_EXEC:   w_next = S_RWB;
      S_IEXEC:  w_next = S_IWB;
      default:  w_next = S_FETCH;
    endcase
  end

  // Only FETCH/MEM_WRITE gate on mem_ready and R_WB on jump_reg; all else is pure state decode.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 3'b000;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_R, OP_J, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW: illegal_op = 1'b0;
          default: illegal_op = 1'b1;
        endcase
      end
      S_MADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MREAD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MWRITE: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
      end
      S_RWB: begin
        alu_op     = 3'b010;
        instr_done = 1'b1;
        if (jump_reg) begin
          pc_write  = 1'b1;
          pc_source = 2'b11;
        end else begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b001;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (opcode)
          OP_ANDI: alu_op = 3'b011;
          OP_ORI:  alu_op = 3'b100;
          default: alu_op = 3'b000;
        endcase
      end
      S_IWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench: a per-instruction behavioural model queues the expected
// control vector for every cycle; a monitor pops and compares each cycle.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic       pw, pwc;
    logic [1:0] ps;
    logic       iod, mr, mw, irw, m2r, rd, rw, asa;
    logic [1:0] asb;
    logic [2:0] aop;
    logic       done, ill;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic       jump_reg = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] pc_source, alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;
  exp_t q[$];
  exp_t act;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .jump_reg(jump_reg),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .instr_done(instr_done),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  assign act = '{state, pc_write, pc_write_cond, pc_source, i_or_d, mem_read,
                 mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                 alu_src_b, alu_op, instr_done, illegal_op};

  task automatic check(input string name, input exp_t e);
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s t=%0t got st=%0d vec=%h expected st=%0d vec=%h",
               name, $time, act.st, act, e.st, e);
    end
  endtask

  // Monitor: DUT outputs are sampled mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (q.size() != 0) check("cycle", q.pop_front());
  end

  function automatic exp_t z(input logic [3:0] st);
    exp_t e = '0;
    e.st = st;
    return e;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic cyc(input exp_t e, input logic [5:0] op, input logic mrdy, input logic jr);
    @(posedge clk);
    #1;
    opcode = op;
    mem_ready = mrdy;
    jump_reg = jr;
    q.push_back(e);
  endtask

  // One whole instruction from FETCH to its last cycle. abort_sw stops a sw
  // after its first MEM_WRITE wait cycle so reset can be asserted mid-access.
  task automatic run(input logic [5:0] op, input int fw, input int mw,
                     input logic jr, input bit abort_sw = 0);
    exp_t e;
    for (int i = 0; i < fw; i++) begin
      e = z(4'd1); e.mr = 1; e.asb = 2'b01;
      cyc(e, op, 1'b0, rb());
    end
    e = z(4'd1); e.mr = 1; e.asb = 2'b01; e.irw = 1; e.pw = 1;
    cyc(e, op, 1'b1, rb());
    e = z(4'd2); e.asb = 2'b11;
    case (op)
      6'h00, 6'h02, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B: ;
      default: e.ill = 1;
    endcase
    cyc(e, op, rb(), rb());
    case (op)
      6'h23, 6'h2B: begin
        e = z(4'd3); e.asa = 1; e.asb = 2'b10;
        cyc(e, op, rb(), rb());
        for (int i = 0; i < mw; i++) begin
          e = (op == 6'h23) ? z(4'd4) : z(4'd6);
          e.iod = 1;
          if (op == 6'h23) e.mr = 1; else e.mw = 1;
          cyc(e, op, 1'b0, rb());
          if (abort_sw) return;
        end
        e = (op == 6'h23) ? z(4'd4) : z(4'd6);
        e.iod = 1;
        if (op == 6'h23) e.mr = 1; else begin e.mw = 1; e.done = 1; end
        cyc(e, op, 1'b1, rb());
        if (op == 6'h23) begin
          e = z(4'd5); e.rw = 1; e.m2r = 1; e.done = 1;
          cyc(e, op, rb(), rb());
        end
      end
      6'h00: begin
        e = z(4'd7); e.asa = 1; e.aop = 3'b010;
        cyc(e, op, rb(), rb());
        e = z(4'd8); e.aop = 3'b010; e.done = 1;
        if (jr) begin e.pw = 1; e.ps = 2'b11; end
        else begin e.rw = 1; e.rd = 1; end
        cyc(e, op, rb(), jr);
      end
      6'h04: begin
        e = z(4'd9); e.asa = 1; e.aop = 3'b001; e.pwc = 1; e.ps = 2'b01; e.done = 1;
        cyc(e, op, rb(), rb());
      end
      6'h02: begin
        e = z(4'd10); e.pw = 1; e.ps = 2'b10; e.done = 1;
        cyc(e, op, rb(), rb());
      end
      6'h08, 6'h0C, 6'h0D: begin
        e = z(4'd11); e.asa = 1; e.asb = 2'b10;
        e.aop = (op == 6'h0C) ? 3'b011 : (op == 6'h0D) ? 3'b100 : 3'b000;
        cyc(e, op, rb(), rb());
        e = z(4'd12); e.rw = 1; e.done = 1;
        cyc(e, op, rb(), rb());
      end
      default: ;
    endcase
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_ready = rb();
    q.push_back(z(4'd0));
  endtask

  logic [5:0] legal [8] = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B};

  initial begin
    logic [5:0] op;
    int guard;
    #2;
    check("reset_state", z(4'd0));
    release_reset();
    run(6'h00, 0, 0, 1'b0);          // add
    run(6'h23, 2, 3, 1'b0);          // lw with waits
    run(6'h00, 0, 0, 1'b1);          // jr
    run(6'h0D, 0, 0, 1'b0);          // ori
    run(6'h04, 0, 0, 1'b0);          // beq
    run(6'h02, 0, 0, 1'b0);          // j
    run(6'h3F, 0, 0, 1'b0);          // illegal
    run(6'h08, 1, 0, 1'b0);
    run(6'h0C, 0, 0, 1'b0);
    run(6'h2B, 0, 2, 1'b0);
    // sw stalled in MEM_WRITE, then asynchronous reset between clock edges
    run(6'h2B, 0, 3, 1'b0, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_mid_write", z(4'd0));
    @(posedge clk);
    #1;
    check("reset_hold", z(4'd0));
    release_reset();
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        op = 6'($urandom_range(0, 63));
        if (op inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B}) op = 6'h3F;
      end else op = legal[$urandom_range(0, 7)];
      run(op, $urandom_range(0, 2), $urandom_range(0, 3), rb());
    end
    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Main control FSM for the multicycle MIPS datapath. Decodes the instruction opcode, sequences fetch/decode/execute/memory/writeback over several clocks, drives every datapath enable and mux select, and issues the 3-bit ALUOp to the ALU control unit. It consumes that unit's JumpReg flag to complete `jr`. Memory accesses use a ready handshake, so the FSM absorbs variable-latency memory.

## Interface
Parameters:
- none. All encodings are fixed.

Ports:
- clk  in  1  system clock. All state changes happen on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26]. Sampled in DECODE and in later states.
- jump_reg  in  1  JumpReg from the ALU control unit. Valid in R_WB.
- mem_ready  in  1  memory has completed the current read or write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero.
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 register rs.
- i_or_d  out  1  0 selects PC as memory address, 1 selects ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  writeback source is MDR.
- reg_dst  out  1  destination register is rd (1) or rt (0).
- reg_write  out  1  register file write.
- alu_src_a  out  1  0 selects PC, 1 selects A.
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-extended immediate, 11 immediate shifted left 2.
- alu_op  out  3  000 add, 001 sub, 010 use func field, 011 and, 100 or.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode.
- state  out  4  current state, for debug.

## Operation
- Outputs are a decode of the 4-bit state register, plus the mem_ready gating noted below. Any output not listed for a state is 0.
- Supported opcodes: R-type 0x00, j 0x02, beq 0x04, addi 0x08, andi 0x0C, ori 0x0D, lw 0x23, sw 0x2B.

States, with their active outputs and transitions:
- IDLE (0): all outputs 0. Goes to FETCH unconditionally. This is the reset state.
- FETCH (1): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00.
  - ir_write and pc_write are asserted only while mem_ready=1.
  - Stays in FETCH while mem_ready=0; goes to DECODE on mem_ready=1.
- DECODE (2): alu_src_a=0, alu_src_b=11, alu_op=000 (computes the branch target).
  - lw or sw → MEM_ADDR
  - R-type → EXEC
  - beq → BRANCH
  - j → JUMP
  - addi, andi, ori → IMM_EXEC
  - any other opcode → illegal_op=1, go to FETCH
- MEM_ADDR (3): alu_src_a=1, alu_src_b=10, alu_op=000. lw → MEM_READ; sw → MEM_WRITE.
- MEM_READ (4): mem_read=1, i_or_d=1. Holds until mem_ready, then goes to MEM_WB.
- MEM_WB (5): reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Goes to FETCH.
- MEM_WRITE (6): mem_write=1, i_or_d=1. Holds until mem_ready; on mem_ready, instr_done=1 and go to FETCH.
- EXEC (7): alu_src_a=1, alu_src_b=00, alu_op=010. Goes to R_WB.
- R_WB (8): alu_op=010 is held so the ALU control decode stays stable; instr_done=1; goes to FETCH.
  - jump_reg=0: reg_write=1, reg_dst=1, mem_to_reg=0.
  - jump_reg=1: pc_write=1, pc_source=11, reg_write=0.
- BRANCH (9): alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_source=01, instr_done=1. Goes to FETCH.
- JUMP (10): pc_write=1, pc_source=10, instr_done=1. Goes to FETCH.
- IMM_EXEC (11): alu_src_a=1, alu_src_b=10, alu_op as follows. Goes to IMM_WB.
  - addi → 000
  - andi → 011
  - ori → 100
- IMM_WB (12): reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Goes to FETCH.
- Codes 13–15 are unreachable. If entered, go to FETCH with all outputs 0.

## Timing
- Reset: an asynchronous assert forces state=IDLE, so all outputs are 0 immediately, including any memory request in flight. After rst_n rises, the first edge goes to FETCH.
- Latency in cycles, with zero memory wait (mem_ready=1 on first request):
  - beq, j: 3
  - R-type, jr, addi, andi, ori, sw: 4
  - lw: 5
  - illegal opcode: 2
- Each memory wait cycle (mem_ready=0) adds 1 cycle. The request outputs (mem_read/mem_write, i_or_d) stay constant during wait cycles.
- mem_ready is ignored outside FETCH, MEM_READ and MEM_WRITE.
- jump_reg is sampled combinationally in R_WB only; no registered copy is kept.
- Exactly one instr_done pulse per completed instruction. No instr_done for an illegal opcode.

## Test plan
- Reset then R-type add, mem_ready tied 1 → state sequence 0,1,2,7,8,1. alu_op=010 in EXEC; reg_write=1 and reg_dst=1 in R_WB; instr_done pulses once.
- lw with mem_ready low for 2 cycles in FETCH and 3 in MEM_READ → total 10 cycles.
  - ir_write and pc_write are high only in the FETCH ready cycle.
  - mem_read and i_or_d=1 are steady through all MEM_READ wait cycles.
  - MEM_WB has reg_write=1, mem_to_reg=1.
- jr (opcode 0x00, jump_reg=1 in R_WB) → pc_write=1, pc_source=11, reg_write=0. Then ori: alu_op=100 in IMM_EXEC.
- beq, then j, then opcode 0x3F.
  - beq: alu_op=001 with pc_write_cond=1.
  - j: pc_write=1 with pc_source=10.
  - 0x3F: illegal_op pulses in DECODE, FETCH follows, no instr_done.
- Assert rst_n low mid-MEM_WRITE while mem_ready=0 → mem_write drops to 0 the same cycle, with no clock edge needed. After release, IDLE then FETCH.
